// File: rtl/id_operand_stage_pkg.sv
// Shared core package for the ID operand stage: default widths, the x0 index
// and the per-edge stage-register action type.
package id_operand_stage_pkg;

  localparam int unsigned DWIDTH_DEF = 32;
  localparam int unsigned AWIDTH_DEF = 5;
  localparam int unsigned REG_X0     = 0;

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_FLUSH
  } stage_act_e;

endpackage

// File: rtl/id_operand_stage_if.sv
// Bundle of ID, register-file, writeback and EX-side signals of the operand stage.
// The slave modport is the stage itself; the master modport is its surroundings.
interface id_operand_stage_if
  import id_operand_stage_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
);

  logic              id_valid;
  logic [AWIDTH-1:0] id_rs1;
  logic [AWIDTH-1:0] id_rs2;
  logic [AWIDTH-1:0] id_rd;
  logic              id_rd_we;
  logic              id_is_load;

  logic [AWIDTH-1:0] rf_addr1;
  logic [AWIDTH-1:0] rf_addr2;
  logic [DWIDTH-1:0] rf_q1;
  logic [DWIDTH-1:0] rf_q2;

  logic              wb_we;
  logic [AWIDTH-1:0] wb_rd;
  logic [DWIDTH-1:0] wb_data;

  logic              ex_ready;
  logic              flush;
  logic              id_ready;
  logic              load_use_stall;

  logic              ex_valid;
  logic [DWIDTH-1:0] ex_rs1_data;
  logic [DWIDTH-1:0] ex_rs2_data;
  logic [AWIDTH-1:0] ex_rd;
  logic              ex_rd_we;
  logic              ex_is_load;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rd_we, id_is_load,
    output rf_addr1, rf_addr2,
    input  rf_q1, rf_q2,
    input  wb_we, wb_rd, wb_data,
    input  ex_ready, flush,
    output id_ready, load_use_stall,
    output ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_we, ex_is_load
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rd_we, id_is_load,
    input  rf_addr1, rf_addr2,
    output rf_q1, rf_q2,
    output wb_we, wb_rd, wb_data,
    output ex_ready, flush,
    input  id_ready, load_use_stall,
    input  ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_we, ex_is_load
  );

endinterface

// File: rtl/id_operand_stage_hazard_unit.sv
// Combinational hazard/bypass logic: operand select, load-use detection and
// bubble/ready generation. ID_WB_BYPASS_EN selects forwarding over stalling.
module id_hazard_unit
  import id_operand_stage_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              i_id_valid,
  input  logic [AWIDTH-1:0] i_id_rs1,
  input  logic [AWIDTH-1:0] i_id_rs2,
  input  logic [DWIDTH-1:0] i_rf_q1,
  input  logic [DWIDTH-1:0] i_rf_q2,
  input  logic              i_wb_we,
  input  logic [AWIDTH-1:0] i_wb_rd,
`ifdef ID_WB_BYPASS_EN
  input  logic [DWIDTH-1:0] i_wb_data,
`endif
  input  logic              i_ex_valid,
  input  logic              i_ex_is_load,
  input  logic              i_ex_rd_we,
  input  logic [AWIDTH-1:0] i_ex_rd,
  input  logic              i_ex_ready,
  input  logic              i_flush,
  output logic [DWIDTH-1:0] o_op1,
  output logic [DWIDTH-1:0] o_op2,
  output logic              o_load_use_stall,
  output logic              o_bubble,
  output logic              o_id_ready
);

  localparam logic [AWIDTH-1:0] X0 = AWIDTH'(REG_X0);

  logic w_rs1_zero;
  logic w_rs2_zero;
  logic w_wb_live;
  logic w_wb_hit1;
  logic w_wb_hit2;
  logic w_wb_hazard;

  assign w_rs1_zero = (i_id_rs1 == X0);
  assign w_rs2_zero = (i_id_rs2 == X0);
  assign w_wb_live  = i_wb_we && (i_wb_rd != X0);
  assign w_wb_hit1  = w_wb_live && (i_wb_rd == i_id_rs1);
  assign w_wb_hit2  = w_wb_live && (i_wb_rd == i_id_rs2);

  assign o_load_use_stall = i_id_valid && i_ex_valid && i_ex_is_load && i_ex_rd_we &&
                            (i_ex_rd != X0) &&
                            ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

`ifdef ID_WB_BYPASS_EN
  assign o_op1       = w_rs1_zero ? '0 : (w_wb_hit1 ? i_wb_data : i_rf_q1);
  assign o_op2       = w_rs2_zero ? '0 : (w_wb_hit2 ? i_wb_data : i_rf_q2);
  assign w_wb_hazard = 1'b0;
`else
  // Without forwarding, a same-cycle writeback to a source forces one bubble
  assign o_op1       = w_rs1_zero ? '0 : i_rf_q1;
  assign o_op2       = w_rs2_zero ? '0 : i_rf_q2;
  assign w_wb_hazard = i_id_valid && (w_wb_hit1 || w_wb_hit2);
`endif

  assign o_bubble   = o_load_use_stall || w_wb_hazard;
  assign o_id_ready = i_ex_ready && !o_bubble && !i_flush;

endmodule

// File: rtl/id_operand_stage.sv
// ID operand stage: register-file read, hazard handling and the ID->EX register.
// Define ID_WB_BYPASS_EN to forward writeback data instead of stalling.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  id_operand_stage_if.slave  bus
);

  localparam logic [AWIDTH-1:0] X0 = AWIDTH'(REG_X0);

  logic [DWIDTH-1:0] w_op1;
  logic [DWIDTH-1:0] w_op2;
  logic              w_load_use_stall;
  logic              w_bubble;
  logic              w_id_ready;
  logic              w_refresh1;
  logic              w_refresh2;
  stage_act_e        w_act;

  logic              r_valid;
  logic [DWIDTH-1:0] r_rs1_data;
  logic [DWIDTH-1:0] r_rs2_data;
  logic [AWIDTH-1:0] r_rd;
  logic              r_rd_we;
  logic              r_is_load;
  logic [AWIDTH-1:0] r_held_rs1;
  logic [AWIDTH-1:0] r_held_rs2;

  id_hazard_unit #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_hazard (
    .i_id_valid       (bus.id_valid),
    .i_id_rs1         (bus.id_rs1),
    .i_id_rs2         (bus.id_rs2),
    .i_rf_q1          (bus.rf_q1),
    .i_rf_q2          (bus.rf_q2),
    .i_wb_we          (bus.wb_we),
    .i_wb_rd          (bus.wb_rd),
`ifdef ID_WB_BYPASS_EN
    .i_wb_data        (bus.wb_data),
`endif
    .i_ex_valid       (r_valid),
    .i_ex_is_load     (r_is_load),
    .i_ex_rd_we       (r_rd_we),
    .i_ex_rd          (r_rd),
    .i_ex_ready       (bus.ex_ready),
    .i_flush          (bus.flush),
    .o_op1            (w_op1),
    .o_op2            (w_op2),
    .o_load_use_stall (w_load_use_stall),
    .o_bubble         (w_bubble),
    .o_id_ready       (w_id_ready)
  );

  // A held instruction picks up writebacks to its own sources while EX is busy
  assign w_refresh1 = bus.wb_we && (bus.wb_rd != X0) && (bus.wb_rd == r_held_rs1);
  assign w_refresh2 = bus.wb_we && (bus.wb_rd != X0) && (bus.wb_rd == r_held_rs2);

  always_comb begin
    w_act = ACT_CAPTURE;
    if (bus.flush)         w_act = ACT_FLUSH;
    else if (!bus.ex_ready) w_act = ACT_HOLD;
    else if (w_bubble)     w_act = ACT_BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rd       <= '0;
      r_rd_we    <= 1'b0;
      r_is_load  <= 1'b0;
      r_held_rs1 <= '0;
      r_held_rs2 <= '0;
    end else begin
      unique case (w_act)
        ACT_HOLD: begin
          if (w_refresh1) r_rs1_data <= bus.wb_data;
          if (w_refresh2) r_rs2_data <= bus.wb_data;
        end
        ACT_CAPTURE: begin
          r_valid    <= bus.id_valid;
          r_rs1_data <= w_op1;
          r_rs2_data <= w_op2;
          r_rd       <= bus.id_rd;
          r_rd_we    <= bus.id_valid && bus.id_rd_we;
          r_is_load  <= bus.id_valid && bus.id_is_load;
          r_held_rs1 <= bus.id_valid ? bus.id_rs1 : X0;
          r_held_rs2 <= bus.id_valid ? bus.id_rs2 : X0;
        end
        default: begin
          r_valid    <= 1'b0;
          r_rs1_data <= '0;
          r_rs2_data <= '0;
          r_rd       <= '0;
          r_rd_we    <= 1'b0;
          r_is_load  <= 1'b0;
          r_held_rs1 <= '0;
          r_held_rs2 <= '0;
        end
      endcase
    end
  end

  assign bus.rf_addr1       = bus.id_rs1;
  assign bus.rf_addr2       = bus.id_rs2;
  assign bus.id_ready       = w_id_ready;
  assign bus.load_use_stall = w_load_use_stall;
  assign bus.ex_valid       = r_valid;
  assign bus.ex_rs1_data    = r_rs1_data;
  assign bus.ex_rs2_data    = r_rs2_data;
  assign bus.ex_rd          = r_rd;
  assign bus.ex_rd_we       = r_rd_we;
  assign bus.ex_is_load     = r_is_load;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: expected EX payloads go into a scoreboard
// queue as each step is driven and are popped and checked after the clock edge.
module tb_id_operand_stage;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        rdWe;
    logic        isLoad;
    bit          careData;
  } exp_t;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;
  exp_t sbQueue[$];

  id_operand_stage_if #(.DWIDTH(32), .AWIDTH(5)) bus ();

  id_operand_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic we, input logic ld,
                               input logic [31:0] q1, input logic [31:0] q2);
    bus.id_valid   = v;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.id_rd      = rd;
    bus.id_rd_we   = we;
    bus.id_is_load = ld;
    bus.rf_q1      = q1;
    bus.rf_q2      = q2;
  endtask

  task automatic setWb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_we   = we;
    bus.wb_rd   = rd;
    bus.wb_data = data;
  endtask

  task automatic setCtl(input logic exReady, input logic fl);
    bus.ex_ready = exReady;
    bus.flush    = fl;
  endtask

  task automatic pushExp(input string tag, input logic v, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [4:0] rd, input logic we,
                         input logic ld, input bit care);
    exp_t e;
    e.tag = tag; e.valid = v; e.d1 = d1; e.d2 = d2; e.rd = rd;
    e.rdWe = we; e.isLoad = ld; e.careData = care;
    sbQueue.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQueue.size() == 0) begin
      checkCount++;
      errorCount++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sbQueue.pop_front();
      compareVal({e.tag, ".ex_valid"},   32'(bus.ex_valid),   32'(e.valid));
      compareVal({e.tag, ".ex_rd_we"},   32'(bus.ex_rd_we),   32'(e.rdWe));
      compareVal({e.tag, ".ex_is_load"}, 32'(bus.ex_is_load), 32'(e.isLoad));
      if (e.careData) begin
        compareVal({e.tag, ".ex_rs1_data"}, bus.ex_rs1_data, e.d1);
        compareVal({e.tag, ".ex_rs2_data"}, bus.ex_rs2_data, e.d2);
        compareVal({e.tag, ".ex_rd"},       32'(bus.ex_rd),  32'(e.rd));
      end
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    setWb(0, 0, 32'h0);
    setCtl(1, 0);

    // Reset state
    pushExp("reset", 0, 32'h0, 32'h0, 5'd0, 0, 0, 1);
    tick();
    checkOutput();
    rst = 1'b0;

    // Plain capture and register-file address passthrough
    applyStimulus(1, 5'd3, 5'd4, 5'd10, 1, 0, 32'h1234, 32'h5678);
    #1;
    compareVal("rf_addr1", 32'(bus.rf_addr1), 32'd3);
    compareVal("rf_addr2", 32'(bus.rf_addr2), 32'd4);
    compareVal("basic.id_ready", 32'(bus.id_ready), 32'd1);
    pushExp("capture_basic", 1, 32'h1234, 32'h5678, 5'd10, 1, 0, 1);
    tick();
    checkOutput();

    // Same-cycle writeback to rs1
    applyStimulus(1, 5'd5, 5'd6, 5'd11, 1, 0, 32'h11, 32'h22);
    setWb(1, 5'd5, 32'hAA);
    #1;
`ifdef ID_WB_BYPASS_EN
    compareVal("bypass.id_ready", 32'(bus.id_ready), 32'd1);
    pushExp("bypass_rs1", 1, 32'hAA, 32'h22, 5'd11, 1, 0, 1);
    tick();
    checkOutput();
`else
    compareVal("wbhaz.id_ready", 32'(bus.id_ready), 32'd0);
    pushExp("wbhaz_bubble", 0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    tick();
    checkOutput();
    setWb(0, 5'd0, 32'h0);
    #1;
    compareVal("wbhaz_after.id_ready", 32'(bus.id_ready), 32'd1);
    pushExp("wbhaz_capture", 1, 32'h11, 32'h22, 5'd11, 1, 0, 1);
    tick();
    checkOutput();
`endif
    setWb(0, 5'd0, 32'h0);

    // Load-use: lw x7 followed by add x8,x7,x1
    applyStimulus(1, 5'd2, 5'd0, 5'd7, 1, 1, 32'h100, 32'h999);
    pushExp("lw_x7", 1, 32'h100, 32'h0, 5'd7, 1, 1, 1);
    tick();
    checkOutput();
    applyStimulus(1, 5'd7, 5'd1, 5'd8, 1, 0, 32'h77, 32'h1);
    #1;
    compareVal("lu.load_use_stall", 32'(bus.load_use_stall), 32'd1);
    compareVal("lu.id_ready", 32'(bus.id_ready), 32'd0);
    pushExp("lu_bubble", 0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    tick();
    checkOutput();
    compareVal("lu_after.load_use_stall", 32'(bus.load_use_stall), 32'd0);
    compareVal("lu_after.id_ready", 32'(bus.id_ready), 32'd1);
    pushExp("lu_capture", 1, 32'h77, 32'h1, 5'd8, 1, 0, 1);
    tick();
    checkOutput();

    // Hold for three cycles with a writeback to held rs2 mid-stall
    applyStimulus(1, 5'd8, 5'd9, 5'd12, 1, 0, 32'h80, 32'h90);
    pushExp("hold_cap", 1, 32'h80, 32'h90, 5'd12, 1, 0, 1);
    tick();
    checkOutput();
    setCtl(0, 0);
    applyStimulus(1, 5'd1, 5'd2, 5'd13, 1, 0, 32'h1, 32'h2);
    #1;
    compareVal("hold.id_ready", 32'(bus.id_ready), 32'd0);
    pushExp("hold_c1", 1, 32'h80, 32'h90, 5'd12, 1, 0, 1);
    tick();
    checkOutput();
    setWb(1, 5'd9, 32'h55);
    pushExp("hold_c2", 1, 32'h80, 32'h55, 5'd12, 1, 0, 1);
    tick();
    checkOutput();
    setWb(1, 5'd20, 32'hEE);
    pushExp("hold_c3", 1, 32'h80, 32'h55, 5'd12, 1, 0, 1);
    tick();
    checkOutput();
    setWb(0, 5'd0, 32'h0);
    setCtl(1, 0);
    pushExp("hold_release", 1, 32'h1, 32'h2, 5'd13, 1, 0, 1);
    tick();
    checkOutput();

    // Flush wins over hold
    setCtl(0, 1);
    applyStimulus(1, 5'd3, 5'd4, 5'd14, 1, 1, 32'h3, 32'h4);
    #1;
    compareVal("flush.id_ready", 32'(bus.id_ready), 32'd0);
    pushExp("flush", 0, 32'h0, 32'h0, 5'd0, 0, 0, 1);
    tick();
    checkOutput();
    setCtl(1, 0);

    // Register 0 is never bypassed and never causes a stall
    applyStimulus(1, 5'd0, 5'd3, 5'd0, 1, 1, 32'h33, 32'h44);
    setWb(1, 5'd0, 32'hFF);
    #1;
    compareVal("x0_wb.id_ready", 32'(bus.id_ready), 32'd1);
    pushExp("x0_lw", 1, 32'h0, 32'h44, 5'd0, 1, 1, 1);
    tick();
    checkOutput();
    setWb(0, 5'd0, 32'h0);
    applyStimulus(1, 5'd0, 5'd5, 5'd9, 1, 0, 32'h33, 32'h50);
    #1;
    compareVal("x0_lu.load_use_stall", 32'(bus.load_use_stall), 32'd0);
    compareVal("x0_lu.id_ready", 32'(bus.id_ready), 32'd1);
    pushExp("x0_after", 1, 32'h0, 32'h50, 5'd9, 1, 0, 1);
    tick();
    checkOutput();

    // Reset during hold discards the held instruction
    setCtl(0, 0);
    rst = 1'b1;
    pushExp("rst_hold", 0, 32'h0, 32'h0, 5'd0, 0, 0, 1);
    tick();
    checkOutput();
    rst = 1'b0;
    applyStimulus(1, 5'd4, 5'd6, 5'd15, 1, 0, 32'h40, 32'h60);
    pushExp("post_rst_hold", 0, 32'h0, 32'h0, 5'd0, 0, 0, 1);
    tick();
    checkOutput();
    setCtl(1, 0);
    pushExp("post_rst_cap", 1, 32'h40, 32'h60, 5'd15, 1, 0, 1);
    tick();
    checkOutput();

    // Idle capture clears valid and write-enable
    applyStimulus(0, 5'd1, 5'd2, 5'd16, 1, 1, 32'h5, 32'h6);
    pushExp("idle", 0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    tick();
    checkOutput();

    compareVal("scoreboard_drained", 32'(sbQueue.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
